// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: state encodings, GAP length
// and the data-grant starvation limit.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDread  = 3'd2,
        StDwrite = 3'd3,
        StGap    = 3'd4
    } arb_state_e;

    // Strobe-low cycles between two accesses (done is shown during this window)
    localparam int unsigned GapCycles   = 1;
    // Consecutive data grants allowed while fetch is waiting
    localparam int unsigned StarveLimit = 2;
    localparam int unsigned StarveW     = 2;
    localparam int unsigned GapW        = 2;

endpackage

// File: rtl/arb_timeout_counter.sv
// Access watchdog for the memory port arbiter. Cleared outside accesses,
// counts each access cycle and flags the last allowed cycle.
module arb_timeout_counter #(
    parameter int unsigned Limit = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Expire in the Limit-th access cycle so the FSM leaves on that edge
    always_comb begin
        expire_o = en_i && (cnt_q == CntW'(Limit - 1));
        cnt_d    = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data requests win in IDLE unless fetch has waited through StarveLimit data
// grants. Each access is followed by one strobe-low GAP cycle carrying done.
// Optional: define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES with err.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic [WORD_SIZE-1:0] if_rdata,
    output logic                 if_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    output logic                 err,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput
);

    arb_state_e           state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 owner_fetch_q, owner_fetch_d;
    logic [StarveW-1:0]   starve_q, starve_d;
    logic [GapW-1:0]      gap_q, gap_d;
    logic                 readm_q, readm_d;
    logic                 writem_q, writem_d;
    logic                 if_done_q, if_done_d;
    logic                 d_done_q, d_done_d;
    logic                 err_q, err_d;
    logic                 expire;

`ifdef MEM_TIMEOUT_EN
    logic in_access;

    assign in_access = (state_q == StFetch) || (state_q == StDread) || (state_q == StDwrite);

    arb_timeout_counter #(
        .Limit (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (!in_access),
        .en_i     (in_access),
        .expire_o (expire)
    );
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state, grant, capture and registered-output decode
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        owner_fetch_d = owner_fetch_q;
        starve_d      = starve_q;
        gap_d         = '0;
        err_d         = 1'b0;

        case (state_q)
            StIdle: begin
                if (d_req && !(if_req && (starve_q >= StarveW'(StarveLimit)))) begin
                    owner_fetch_d = 1'b0;
                    addr_d        = d_addr;
                    wdata_d       = d_wdata;
                    state_d       = d_we ? StDwrite : StDread;
                    // Only grants that make fetch wait count toward starvation
                    if (if_req) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (if_req) begin
                    owner_fetch_d = 1'b1;
                    addr_d        = if_addr;
                    state_d       = StFetch;
                    starve_d      = '0;
                end
            end
            StFetch: begin
                if (inputReady) begin
                    if_rdata_d = data;
                    state_d    = StGap;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = StGap;
                end
            end
            StDread: begin
                if (inputReady) begin
                    d_rdata_d = data;
                    state_d   = StGap;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = StGap;
                end
            end
            StDwrite: begin
                if (ackOutput) begin
                    state_d = StGap;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GapW'(GapCycles - 1)) begin
                    state_d = StIdle;
                end else begin
                    err_d = err_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs follow the state being entered so they are registered
        readm_d   = (state_d == StFetch) || (state_d == StDread);
        writem_d  = (state_d == StDwrite);
        if_done_d = (state_d == StGap) && owner_fetch_d;
        d_done_d  = (state_d == StGap) && !owner_fetch_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wdata_q       <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            owner_fetch_q <= 1'b0;
            starve_q      <= '0;
            gap_q         <= '0;
            readm_q       <= 1'b0;
            writem_q      <= 1'b0;
            if_done_q     <= 1'b0;
            d_done_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            owner_fetch_q <= owner_fetch_d;
            starve_q      <= starve_d;
            gap_q         <= gap_d;
            readm_q       <= readm_d;
            writem_q      <= writem_d;
            if_done_q     <= if_done_d;
            d_done_q      <= d_done_d;
            err_q         <= err_d;
        end
    end

    assign readM    = readm_q;
    assign writeM   = writem_q;
    assign address  = addr_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_done  = if_done_q;
    assign d_done   = d_done_q;
    assign err      = err_q;
    assign data     = writem_q ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a latency-programmable memory
// model and an in-order completion scoreboard.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    wire  [15:0] if_rdata;
    wire         if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    wire  [15:0] d_rdata;
    wire         d_done;
    wire         err;
    wire         readM;
    wire         writeM;
    wire  [15:0] address;
    wire  [15:0] data;
    logic        inputReady = 1'b0;
    logic        ackOutput = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .WORD_SIZE      (16),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .err        (err),
        .readM      (readM),
        .writeM     (writeM),
        .address    (address),
        .data       (data),
        .inputReady (inputReady),
        .ackOutput  (ackOutput)
    );

    function automatic logic [15:0] rd_model(input logic [15:0] a);
        if (a == 16'h0010) return 16'h9A01;
        return a ^ 16'hC3A5;
    endfunction

    // Memory model: responds in strobe cycle resp_at (1 = same cycle, 0 = never)
    int          resp_at = 2;
    int          scnt = 0;
    logic        mem_drive = 1'b0;
    logic [15:0] mem_out = '0;

    assign data = mem_drive ? mem_out : 16'hzzzz;

    always @(negedge clk) begin
        if (readM || writeM) scnt = scnt + 1;
        else scnt = 0;
        inputReady = readM && (resp_at != 0) && (scnt == resp_at);
        ackOutput  = writeM && (resp_at != 0) && (scnt == resp_at);
        mem_drive  = readM;
        mem_out    = rd_model(address);
    end

    typedef struct {
        bit          fetch;
        bit          store;
        logic [15:0] addr;
        logic [15:0] val;
        bit          err;
    } exp_t;

    exp_t sb[$];

    // Scoreboard monitor: checks strobes against the access at the queue head
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (readM && writeM) begin
                total++; bad++;
                $display("FAIL strobe_excl readM=%0b writeM=%0b required not both", readM, writeM);
            end
            if ((readM || writeM) && (if_done || d_done)) begin
                total++; bad++;
                $display("FAIL gap_strobe strobe high during done cycle");
            end
            if (readM || writeM) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_unexpected addr=%h with no access expected", address);
                end else begin
                    if (address !== sb[0].addr || writeM !== sb[0].store) begin
                        bad++;
                        $display("FAIL access_addr got addr=%h we=%0b required addr=%h we=%0b",
                                 address, writeM, sb[0].addr, sb[0].store);
                    end
                    if (writeM && data !== sb[0].val) begin
                        bad++;
                        $display("FAIL wr_bus got %h required %h", data, sb[0].val);
                    end
                end
            end
            if (if_done || d_done) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected if_done=%0b d_done=%0b", if_done, d_done);
                end else begin
                    e = sb.pop_front();
                    if (if_done !== e.fetch || d_done === if_done) begin
                        bad++;
                        $display("FAIL done_kind got if_done=%0b d_done=%0b required fetch=%0b",
                                 if_done, d_done, e.fetch);
                    end
                    if (err !== e.err) begin
                        bad++;
                        $display("FAIL done_err got %0b required %0b", err, e.err);
                    end
                    if (!e.store && ((e.fetch ? if_rdata : d_rdata) !== e.val)) begin
                        bad++;
                        $display("FAIL rdata addr=%h got %h required %h", e.addr,
                                 e.fetch ? if_rdata : d_rdata, e.val);
                    end
                end
            end
        end
    end

    function automatic exp_t mk(input bit f, input bit s, input logic [15:0] a,
                                input logic [15:0] v, input bit er);
        exp_t e;
        e.fetch = f; e.store = s; e.addr = a; e.val = v; e.err = er;
        return e;
    endfunction

    task automatic do_fetch(input logic [15:0] a);
        bit got = 0;
        if_addr = a;
        if_req  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_done) begin got = 1; break; end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL fetch_wait addr=%h got no if_done required done within 200", a);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [15:0] a, input logic [15:0] wd);
        bit got = 0;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (d_done) begin got = 1; break; end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL data_wait addr=%h got no d_done required done within 200", a);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({readM, writeM, if_done, d_done, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got %b required 00000", {readM, writeM, if_done, d_done, err});
        end
        total++;
        if (address !== 16'h0 || if_rdata !== 16'h0 || d_rdata !== 16'h0) begin
            bad++;
            $display("FAIL reset_regs got addr=%h ir=%h dr=%h required 0", address, if_rdata, d_rdata);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        int n = 0;
        bit got = 0;
        resp_at = 1;
        sb.push_back(mk(1, 0, 16'h0020, rd_model(16'h0020), 0));
        if_addr = 16'h0020;
        if_req  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (if_done) begin got = 1; break; end
        end
        total++;
        if (!got || n != 3) begin
            bad++;
            $display("FAIL min_latency got %0d cycles required 3", n);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic test_fetch();
        resp_at = 3;
        @(posedge clk); #1;
        sb.push_back(mk(1, 0, 16'h0010, 16'h9A01, 0));
        do_fetch(16'h0010);
        total++;
        if (readM !== 1'b0 || if_done !== 1'b0 || if_rdata !== 16'h9A01) begin
            bad++;
            $display("FAIL fetch_after got readM=%0b if_done=%0b ir=%h required 0 0 9a01",
                     readM, if_done, if_rdata);
        end
    endtask

    task automatic test_simultaneous();
        resp_at = 1;
        @(posedge clk); #1;
        sb.push_back(mk(0, 0, 16'h0042, rd_model(16'h0042), 0));
        sb.push_back(mk(1, 0, 16'h0100, rd_model(16'h0100), 0));
        fork
            do_data(1'b0, 16'h0042, 16'h0);
            do_fetch(16'h0100);
        join
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL simul_drain got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_store();
        resp_at = 4;
        @(posedge clk); #1;
        sb.push_back(mk(0, 1, 16'h0080, 16'h1234, 0));
        do_data(1'b1, 16'h0080, 16'h1234);
        total++;
        if (writeM !== 1'b0 || d_done !== 1'b0) begin
            bad++;
            $display("FAIL store_after got writeM=%0b d_done=%0b required 0 0", writeM, d_done);
        end
    endtask

    task automatic test_starvation();
        logic [15:0] da [4];
        logic [15:0] fa [2];
        da[0] = 16'h0300; da[1] = 16'h0302; da[2] = 16'h0304; da[3] = 16'h0306;
        fa[0] = 16'h0400; fa[1] = 16'h0402;
        resp_at = 2;
        @(posedge clk); #1;
        // Expected grant order D, D, F, D, D, F
        sb.push_back(mk(0, 0, da[0], rd_model(da[0]), 0));
        sb.push_back(mk(0, 0, da[1], rd_model(da[1]), 0));
        sb.push_back(mk(1, 0, fa[0], rd_model(fa[0]), 0));
        sb.push_back(mk(0, 0, da[2], rd_model(da[2]), 0));
        sb.push_back(mk(0, 0, da[3], rd_model(da[3]), 0));
        sb.push_back(mk(1, 0, fa[1], rd_model(fa[1]), 0));
        fork
            for (int i = 0; i < 4; i++) do_data(1'b0, da[i], 16'h0);
            for (int j = 0; j < 2; j++) do_fetch(fa[j]);
        join
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL starve_drain got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_hold();
        resp_at = 1;
        @(posedge clk); #1;
        sb.push_back(mk(0, 1, 16'h0500, 16'hBEEF, 0));
        do_data(1'b1, 16'h0500, 16'hBEEF);
        total++;
        if (if_rdata !== rd_model(16'h0402) || d_rdata !== rd_model(16'h0306)) begin
            bad++;
            $display("FAIL rdata_hold got ir=%h dr=%h required %h %h", if_rdata, d_rdata,
                     rd_model(16'h0402), rd_model(16'h0306));
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        resp_at = 0;
        @(posedge clk); #1;
        sb.push_back(mk(0, 0, 16'h0600, 16'h0, 0));
        d_we   = 1'b0;
        d_addr = 16'h0600;
        d_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (readM) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL mid_strobe got readM=0 required 1");
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({readM, writeM, d_done, if_done, err} !== 5'b0 || address !== 16'h0 ||
            d_rdata !== 16'h0 || if_rdata !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset got flags=%b addr=%h dr=%h ir=%h required all 0",
                     {readM, writeM, d_done, if_done, err}, address, d_rdata, if_rdata);
        end
        sb.delete();
        d_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (readM !== 1'b0 || d_done !== 1'b0) begin
                bad++;
                $display("FAIL mid_after got readM=%0b d_done=%0b required 0 0", readM, d_done);
            end
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        bit got = 0;
        resp_at = 0;
        @(posedge clk); #1;
        // d_rdata is 0 after the preceding reset and must stay so
        sb.push_back(mk(0, 0, 16'h0700, 16'h0, 1));
        d_we   = 1'b0;
        d_addr = 16'h0700;
        d_req  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (readM) n++;
            if (d_done) begin got = 1; break; end
        end
        total++;
        if (!got || n != 15 || err !== 1'b1) begin
            bad++;
            $display("FAIL timeout got done=%0b strobe_cycles=%0d err=%0b required 1 15 1",
                     got, n, err);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_fetch();
        test_simultaneous();
        test_store();
        test_starvation();
        test_hold();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL final_drain got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
